// File: rtl/led_chaser_pkg.sv
// led_chaser_pkg: shared encodings for the LED chaser.
// Holds the mode encoding and the bounce direction.
package led_chaser_pkg;

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/led_chaser_tick_gen.sv
// tick_gen: free-running prescaler for the LED chaser.
// It counts 0..DIV-1 while en is high and holds its count while en is low.
// The one-cycle req output is high while the count sits at DIV-1 with en high,
// so the owner of the pattern advances on the same edge at which the count wraps.
// clr zeroes the count and masks req, which lets a pattern load restart the period.
module tick_gen #(
  parameter int DIV = 12000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic req
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Prescaler count: cleared by reset or clr, wraps at DIV-1, frozen while en is low.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  assign req = en && !clr && (count == LAST);

endmodule

// File: rtl/led_chaser.sv
// led_chaser: parametrised LED pattern sequencer.
// The pattern advances on a prescaler request or a manual step pulse, in
// rotate-left, rotate-right, bounce or hold mode. A load replaces the pattern
// and restarts the prescaler period. tick strobes for one cycle per advance
// and heartbeat toggles on every advance.
// Optional feature macro: LED_CHASER_BOUNCE_EN enables bounce mode and the
// direction register; without it, bounce mode behaves as hold.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter int               DIV   = 12000000,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(4'b0101)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_pat,
  input  logic             step,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             heartbeat
);

  logic             req;
  logic             advance;
  logic [WIDTH-1:0] rol_pat;
  logic [WIDTH-1:0] ror_pat;
  logic [WIDTH-1:0] next_led;
  mode_e            mode_sel;

`ifdef LED_CHASER_BOUNCE_EN
  dir_e dir;
  dir_e next_dir;
`endif

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .en     (en),
    .clr    (load),
    .req    (req)
  );

  // A prescaler request and a step in the same cycle merge into one advance.
  assign advance = req | step;

  // Next pattern (and direction) for an advance, selected by the current mode.
  always_comb begin
    mode_sel = mode_e'(mode);
    rol_pat  = {led[WIDTH-2:0], led[WIDTH-1]};
    ror_pat  = {led[0], led[WIDTH-1:1]};
    next_led = led;
`ifdef LED_CHASER_BOUNCE_EN
    next_dir = dir;
`endif
    case (mode_sel)
      MODE_ROL: next_led = rol_pat;
      MODE_ROR: next_led = ror_pat;
`ifdef LED_CHASER_BOUNCE_EN
      MODE_BOUNCE: begin
        if (dir == DIR_LEFT && led[WIDTH-1]) begin
          next_dir = DIR_RIGHT;
          next_led = ror_pat;
        end else if (dir == DIR_RIGHT && led[0]) begin
          next_dir = DIR_LEFT;
          next_led = rol_pat;
        end else if (dir == DIR_LEFT) begin
          next_led = rol_pat;
        end else begin
          next_led = ror_pat;
        end
      end
`endif
      default: next_led = led;
    endcase
  end

  // Pattern, strobe and heartbeat registers: reset, then load, then advance.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      led       <= INIT;
      tick      <= 1'b0;
      heartbeat <= 1'b0;
`ifdef LED_CHASER_BOUNCE_EN
      dir       <= DIR_LEFT;
`endif
    end else if (load) begin
      led       <= load_pat;
      tick      <= 1'b0;
`ifdef LED_CHASER_BOUNCE_EN
      dir       <= DIR_LEFT;
`endif
    end else if (advance) begin
      led       <= next_led;
      tick      <= 1'b1;
      heartbeat <= ~heartbeat;
`ifdef LED_CHASER_BOUNCE_EN
      dir       <= next_dir;
`endif
    end else begin
      tick      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_chaser.sv
// tb_led_chaser: directed self-checking bench for led_chaser (WIDTH=4, DIV=4).
// Bounce expectations follow LED_CHASER_BOUNCE_EN when it is defined.
module tb_led_chaser;

  logic       clk;
  logic       resetn;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [3:0] load_pat;
  logic       step;
  logic [3:0] led;
  logic       tick;
  logic       heartbeat;

  int total;
  int bad;
  logic exp_hb;

  led_chaser #(
    .WIDTH (4),
    .DIV   (4),
    .INIT  (4'b0101)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .mode      (mode),
    .load      (load),
    .load_pat  (load_pat),
    .step      (step),
    .led       (led),
    .tick      (tick),
    .heartbeat (heartbeat)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check the full visible state after an edge.
  task automatic checkState(input string tag, input logic [3:0] exp_led, input logic exp_tick);
    checkOutput({tag, ".led"}, 32'(led), 32'(exp_led));
    checkOutput({tag, ".tick"}, 32'(tick), 32'(exp_tick));
    checkOutput({tag, ".hb"}, 32'(heartbeat), 32'(exp_hb));
  endtask

  // Drive the inputs seen by the next edge, then step past that edge.
  task automatic applyStimulus(input logic l, input logic [3:0] lp, input logic s,
                               input logic e, input logic [1:0] m);
    load     = l;
    load_pat = lp;
    step     = s;
    en       = e;
    mode     = m;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] bounce_exp [8];

  initial begin
    total    = 0;
    bad      = 0;
    exp_hb   = 1'b0;
    resetn   = 1'b0;
    en       = 1'b1;
    mode     = 2'b00;
    load     = 1'b0;
    load_pat = 4'b0000;
    step     = 1'b0;
`ifdef LED_CHASER_BOUNCE_EN
    bounce_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
`else
    bounce_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif

    // Reset state
    @(posedge clk);
    #1;
    checkState("reset", 4'b0101, 1'b0);
    resetn = 1'b1;

    // Automatic rotate-left: first advance DIV cycles after reset release
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 2'b00);
      checkState("rol_wait1", 4'b0101, 1'b0);
    end
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 2'b00);
    exp_hb = ~exp_hb;
    checkState("rol_adv1", 4'b1010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 2'b00);
      checkState("rol_wait2", 4'b1010, 1'b0);
    end
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 2'b00);
    exp_hb = ~exp_hb;
    checkState("rol_adv2", 4'b0101, 1'b1);

    // Load then rotate-right steps; the fourth step lands on count=DIV-1
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1, 2'b01);
    checkState("ror_load", 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 2'b01);
    exp_hb = ~exp_hb;
    checkState("ror_step1", 4'b1000, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 2'b01);
    exp_hb = ~exp_hb;
    checkState("ror_step2", 4'b0100, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 2'b01);
    exp_hb = ~exp_hb;
    checkState("ror_step3", 4'b0010, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1, 2'b01);
    exp_hb = ~exp_hb;
    checkState("ror_step_coincident", 4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 2'b01);
      checkState("ror_wait", 4'b0001, 1'b0);
    end
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 2'b01);
    exp_hb = ~exp_hb;
    checkState("ror_auto", 4'b1000, 1'b1);

    // Bounce mode (hold when the bounce feature is absent), eight back-to-back steps
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 2'b10);
    checkState("bounce_load", 4'b0001, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 2'b10);
      exp_hb = ~exp_hb;
      checkState($sformatf("bounce_adv%0d", i), bounce_exp[i], 1'b1);
    end
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 2'b10);
    checkState("bounce_idle", bounce_exp[7], 1'b0);

    // Prescaler freeze at count=2, then advance two enabled cycles later
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b1, 2'b00);
    checkState("freeze_load", 4'b0001, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 2'b00);
      checkState("freeze_pre", 4'b0001, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 2'b00);
      checkState("freeze_hold", 4'b0001, 1'b0);
    end
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 2'b00);
    checkState("freeze_resume1", 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 2'b00);
    exp_hb = ~exp_hb;
    checkState("freeze_resume2", 4'b0010, 1'b1);

    // Load wins over a coincident step
    applyStimulus(1'b1, 4'b1100, 1'b1, 1'b0, 2'b00);
    checkState("load_vs_step", 4'b1100, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 2'b00);
    exp_hb = ~exp_hb;
    checkState("step_after_load", 4'b1001, 1'b1);

    // Reset while tick is high, with a step pending
    resetn = 1'b0;
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 2'b00);
    exp_hb = 1'b0;
    checkState("reset_mid", 4'b0101, 1'b0);
    resetn = 1'b1;
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 2'b00);
    checkState("post_reset", 4'b0101, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
